// File: rtl/tns_enc_33.sv
// tns_enc_33: sequential greedy encoder from binary data to a 33-bit TNS
// codeword. Weights are scanned from the most significant digit downwards,
// BITS_PER_CYCLE digits per clock, with valid/ready handshakes on both sides.

`ifndef BLEN11
`define BLEN11  32
`endif
`ifndef TNS01_C
`define TNS01_C 1
`define TNS01_B 1
`define TNS01_A 2
`define TNS02_C 4
`define TNS02_B 7
`define TNS02_A 13
`define TNS03_C 24
`define TNS03_B 44
`define TNS03_A 81
`define TNS04_C 149
`define TNS04_B 274
`define TNS04_A 504
`define TNS05_C 927
`define TNS05_B 1705
`define TNS05_A 3136
`define TNS06_C 5768
`define TNS06_B 10609
`define TNS06_A 19513
`define TNS07_C 35890
`define TNS07_B 66012
`define TNS07_A 121415
`define TNS08_C 223317
`define TNS08_B 410744
`define TNS08_A 755476
`define TNS09_C 1389537
`define TNS09_B 2555757
`define TNS09_A 4700770
`define TNS10_C 8646064
`define TNS10_B 15902591
`define TNS10_A 29249425
`define TNS11_C 53798080
`define TNS11_B 98950096
`define TNS11_A 181997601
`endif

// state | meaning
// IDLE  | ready for a new word, no output pending
// CONV  | resolving codeword digits, idx walks 32 down to 0
// DONE  | codeword and error flag presented until out_ready
module tns_enc_33 #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [`BLEN11-1:0] datain,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32:0]        codeout,
    output logic               out_err
);

    localparam int         W        = `BLEN11;
    localparam int         K        = BITS_PER_CYCLE;
    localparam logic [5:0] IDX_TOP  = 6'd32;
    localparam logic [5:0] IDX_LAST = 6'(K - 1);
    localparam logic [5:0] IDX_STEP = 6'(K);

    // Index 0 is the least significant digit (TNS01_C), index 32 is TNS11_A.
    localparam logic [W-1:0] WT [33] = '{
        `TNS01_C, `TNS01_B, `TNS01_A,
        `TNS02_C, `TNS02_B, `TNS02_A,
        `TNS03_C, `TNS03_B, `TNS03_A,
        `TNS04_C, `TNS04_B, `TNS04_A,
        `TNS05_C, `TNS05_B, `TNS05_A,
        `TNS06_C, `TNS06_B, `TNS06_A,
        `TNS07_C, `TNS07_B, `TNS07_A,
        `TNS08_C, `TNS08_B, `TNS08_A,
        `TNS09_C, `TNS09_B, `TNS09_A,
        `TNS10_C, `TNS10_B, `TNS10_A,
        `TNS11_C, `TNS11_B, `TNS11_A
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   res_q, res_d;
    logic [5:0]     idx_q, idx_d;
    logic [32:0]    code_q, code_d;
    logic           err_q, err_d;

    logic [W-1:0]   slice_res;
    logic [32:0]    slice_code;
    logic [5:0]     slice_idx;

    // Resolve K digits starting at idx_q, chaining the residual through them.
    always_comb begin
        slice_res  = res_q;
        slice_code = code_q;
        slice_idx  = idx_q;
        for (int k = 0; k < K; k++) begin
            slice_idx = idx_q - 6'(k);
            if (slice_res >= WT[slice_idx]) begin
                slice_res             = slice_res - WT[slice_idx];
                slice_code[slice_idx] = 1'b1;
            end else begin
                slice_code[slice_idx] = 1'b0;
            end
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        idx_d     = idx_q;
        code_d    = code_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        codeout   = code_q;
        out_err   = err_q;

        unique case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    res_d   = datain;
                    idx_d   = IDX_TOP;
                    code_d  = '0;
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                res_d  = slice_res;
                code_d = slice_code;
                if (idx_q == IDX_LAST) begin
                    err_d   = (slice_res != '0);
                    idx_d   = IDX_TOP;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_STEP;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            idx_q   <= IDX_TOP;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_tns_enc_33.sv
// tb_tns_enc_33: randomized self-checking bench for tns_enc_33, running a
// K=1 and a K=3 instance against a greedy reference encoder.

`ifndef BLEN11
`define BLEN11  32
`endif
`ifndef TNS01_C
`define TNS01_C 1
`define TNS01_B 1
`define TNS01_A 2
`define TNS02_C 4
`define TNS02_B 7
`define TNS02_A 13
`define TNS03_C 24
`define TNS03_B 44
`define TNS03_A 81
`define TNS04_C 149
`define TNS04_B 274
`define TNS04_A 504
`define TNS05_C 927
`define TNS05_B 1705
`define TNS05_A 3136
`define TNS06_C 5768
`define TNS06_B 10609
`define TNS06_A 19513
`define TNS07_C 35890
`define TNS07_B 66012
`define TNS07_A 121415
`define TNS08_C 223317
`define TNS08_B 410744
`define TNS08_A 755476
`define TNS09_C 1389537
`define TNS09_B 2555757
`define TNS09_A 4700770
`define TNS10_C 8646064
`define TNS10_B 15902591
`define TNS10_A 29249425
`define TNS11_C 53798080
`define TNS11_B 98950096
`define TNS11_A 181997601
`endif

module tb_tns_enc_33;

    localparam int W     = `BLEN11;
    localparam int N_RND = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [W-1:0]  datain    [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [32:0]   codeout   [2];
    logic          out_err   [2];

    tns_enc_33 #(.BITS_PER_CYCLE(1)) u_enc_k1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .datain    (datain[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .codeout   (codeout[0]),
        .out_err   (out_err[0])
    );

    tns_enc_33 #(.BITS_PER_CYCLE(3)) u_enc_k3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .datain    (datain[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .codeout   (codeout[1]),
        .out_err   (out_err[1])
    );

    always #5 clk = ~clk;

    longint      wt [33];
    longint      s_total;
    int          vectors     = 0;
    int          miscompares = 0;
    int          lat_exp [2] = '{33, 11};
    logic [32:0] codes_k1 [N_RND];
    longint      vals [N_RND];

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Greedy digit selection straight from the weight list.
    function automatic void ref_enc(input longint data, output logic [32:0] code, output logic err);
        longint rem = data;
        code = '0;
        for (int j = 32; j >= 0; j--) begin
            if (rem >= wt[j]) begin
                code[j] = 1'b1;
                rem     = rem - wt[j];
            end
        end
        err = (rem != 0);
    endfunction

    function automatic longint wsum(input logic [32:0] code);
        longint s = 0;
        for (int j = 0; j < 33; j++) if (code[j]) s += wt[j];
        return s;
    endfunction

    function automatic int popcnt(input logic [32:0] code);
        int c = 0;
        for (int j = 0; j < 33; j++) if (code[j]) c++;
        return c;
    endfunction

    // One word through encoder d with out_ready held high; reports latency.
    task automatic xfer(input int d, input longint data, output logic [32:0] code,
                        output logic err, output int lat);
        int n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk_eq("in_ready_wait", 0, 1);
        in_valid[d]  = 1'b1;
        datain[d]    = W'(data);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        datain[d]   = W'($urandom);
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        code = codeout[d];
        err  = out_err[d];
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input int d, input longint data, input string tag,
                            output logic [32:0] code);
        logic [32:0] exp_code;
        logic        exp_err;
        logic        err;
        int          lat;
        xfer(d, data, code, err, lat);
        ref_enc(data, exp_code, exp_err);
        chk_eq({tag, "_lat"}, lat, lat_exp[d]);
        chk_eq({tag, "_code"}, longint'(code), longint'(exp_code));
        chk_eq({tag, "_err"}, longint'(err), longint'(exp_err));
        if (!exp_err) chk_eq({tag, "_wsum"}, wsum(code), data);
    endtask

    initial begin
        logic [32:0] c, ce;
        logic        e;
        int          n;
        int          seen;
        longint      data_a, data_b;

        wt = '{`TNS01_C, `TNS01_B, `TNS01_A, `TNS02_C, `TNS02_B, `TNS02_A,
               `TNS03_C, `TNS03_B, `TNS03_A, `TNS04_C, `TNS04_B, `TNS04_A,
               `TNS05_C, `TNS05_B, `TNS05_A, `TNS06_C, `TNS06_B, `TNS06_A,
               `TNS07_C, `TNS07_B, `TNS07_A, `TNS08_C, `TNS08_B, `TNS08_A,
               `TNS09_C, `TNS09_B, `TNS09_A, `TNS10_C, `TNS10_B, `TNS10_A,
               `TNS11_C, `TNS11_B, `TNS11_A};
        s_total = 0;
        for (int j = 0; j < 33; j++) s_total += wt[j];

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            datain[d]    = '0;
            out_ready[d] = 1'b1;
        end

        #2;
        chk_eq("rst_in_ready", longint'(in_ready[0]), 0);
        chk_eq("rst_out_valid", longint'(out_valid[0]), 0);
        chk_eq("rst_codeout", longint'(codeout[0]), 0);
        chk_eq("rst_out_err", longint'(out_err[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_eq("rst_rel_in_ready_k1", longint'(in_ready[0]), 1);
        chk_eq("rst_rel_in_ready_k3", longint'(in_ready[1]), 1);

        for (int d = 0; d < 2; d++) begin
            run_word(d, 0, "zero", c);
            run_word(d, wt[32], "top_weight", c);
            chk_eq("top_weight_bit32", longint'(c), longint'(33'h1_0000_0000));
            run_word(d, 1, "one", c);
            chk_eq("one_popcnt", popcnt(c), 1);
            run_word(d, s_total, "sum_max", c);
            if (s_total + 1 < (64'd1 << W)) begin
                run_word(d, s_total + 1, "sum_max_p1", c);
            end
        end

        for (int i = 0; i < N_RND; i++) begin
            vals[i] = longint'($urandom_range(32'(s_total), 0));
            if (i < 4) vals[i] = s_total - longint'(i);
            run_word(0, vals[i], "rnd_k1", codes_k1[i]);
        end
        for (int i = 0; i < N_RND; i++) begin
            run_word(1, vals[i], "rnd_k3", c);
            chk_eq("rnd_k1_k3_same", longint'(c), longint'(codes_k1[i]));
        end

        data_a = 12345;
        data_b = s_total - 7;
        @(negedge clk);
        in_valid[0]  = 1'b1;
        datain[0]    = W'(data_a);
        out_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq("bp_lat", n, 33);
        ref_enc(data_a, ce, e);
        in_valid[0] = 1'b1;
        datain[0]   = W'(data_b);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_eq("bp_hold_valid", longint'(out_valid[0]), 1);
            chk_eq("bp_hold_code", longint'(codeout[0]), longint'(ce));
            chk_eq("bp_hold_err", longint'(out_err[0]), longint'(e));
            chk_eq("bp_hold_in_ready", longint'(in_ready[0]), 0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("bp_after_hs_valid", longint'(out_valid[0]), 0);
        chk_eq("bp_after_hs_in_ready", longint'(in_ready[0]), 1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        chk_eq("bp_new_accepted", longint'(in_ready[0]), 0);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq("bp_new_lat", n, 33);
        ref_enc(data_b, ce, e);
        chk_eq("bp_new_code", longint'(codeout[0]), longint'(ce));
        chk_eq("bp_new_err", longint'(out_err[0]), longint'(e));
        @(posedge clk);
        #1;

        @(negedge clk);
        in_valid[0] = 1'b1;
        datain[0]   = W'(s_total);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_out_valid", longint'(out_valid[0]), 0);
        chk_eq("midrst_codeout", longint'(codeout[0]), 0);
        chk_eq("midrst_out_err", longint'(out_err[0]), 0);
        chk_eq("midrst_in_ready", longint'(in_ready[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_eq("midrst_rel_in_ready", longint'(in_ready[0]), 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) seen++;
        end
        chk_eq("midrst_no_stale_valid", seen, 0);
        run_word(0, 777, "post_rst", c);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
